// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA timing (clk, reset, pixel_on in; x, y, pix_tick, hsync_n, vsync_n, video_on, pixel_out, frame_start out)
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_on,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       pix_tick,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       video_on,
  output logic       pixel_out,
  output logic       frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [3:0] div;
  logic [9:0] h_count, v_count;
  logic div_end, h_end, v_end, active, hs_raw, vs_raw;
  logic hs_r, vs_r, act_r, pix_r;
  assign div_end  = div == 4'(CLK_DIV - 1);
  assign pix_tick = !reset && div_end;
  assign h_end    = h_count == 10'(H_TOTAL - 1);
  assign v_end    = v_count == 10'(V_TOTAL - 1);
  assign active   = h_count < 10'(H_ACTIVE) && v_count < 10'(V_ACTIVE);
  assign hs_raw   = h_count >= 10'(H_ACTIVE + H_FP) && h_count < 10'(H_ACTIVE + H_FP + H_SYNC);
  assign vs_raw   = v_count >= 10'(V_ACTIVE + V_FP) && v_count < 10'(V_ACTIVE + V_FP + V_SYNC);
  assign x         = active ? h_count : '0;
  assign y         = active ? v_count[8:0] : '0;
  assign hsync_n   = !hs_r;
  assign vsync_n   = !vs_r;
  assign video_on  = act_r;
  assign pixel_out = pix_r && act_r;
  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= '0;
      h_count     <= '0;
      v_count     <= '0;
      hs_r        <= 1'b0;
      vs_r        <= 1'b0;
      act_r       <= 1'b0;
      pix_r       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_end ? '0 : div + 4'd1;
      frame_start <= pix_tick && h_end && v_end;
      if (pix_tick) begin
        h_count <= h_end ? '0 : h_count + 10'd1;
        v_count <= h_end ? (v_end ? '0 : v_count + 10'd1) : v_count;
        hs_r    <= hs_raw;
        vs_r    <= vs_raw;
        act_r   <= active;
        pix_r   <= pixel_on;
      end
    end
  end
endmodule
